prime_scan_ctrl: RTL and testbench
==================================

// Module: prime_scan_ctrl
// PURPOSE
//   Sequencer that sweeps an unsigned range [lo..hi] through a primality-test datapath.
//   Streams each prime found out on a valid/ready interface and reports the total on completion.
//   Sits between a host (start/done) and a downstream consumer (e.g. display or FIFO).
// PARAMETERS
//   WIDTH   4   operand width; legal range 2..8 (primality mask built at elaboration)
// PORTS
//   clk          in   1        system clock, rising edge
//   rst_n        in   1        asynchronous active-low reset
//   start        in   1        begin scan; sampled only in IDLE
//   lo           in   WIDTH    range low bound, latched on accepted start
//   hi           in   WIDTH    range high bound (inclusive), latched on accepted start
//   busy         out  1        high in SCAN/EMIT
//   done         out  1        one-cycle pulse at scan completion
//   prime_valid  out  1        prime_data holds a prime
//   prime_ready  in   1        consumer accepts prime_data when valid&ready at clk edge
//   prime_data   out  WIDTH    current prime
//   prime_count  out  WIDTH+1  primes emitted in current/last scan
// BEHAVIOUR
//   Clocking: one clock (clk); reset is asynchronous and active-low (rst_n).
//   Reset: state=IDLE; busy=0, done=0, prime_valid=0, prime_data=0, prime_count=0, cur=0.
//   All outputs are registered.
//   FSM: IDLE, SCAN, EMIT, DONE.
//   IDLE: start=1 -> latch lo/hi, cur<=lo, prime_count<=0.
//     Goes to DONE if lo>hi, else SCAN. start=0 -> stay.
//   SCAN: evaluate is_prime(cur) combinationally.
//     Prime -> prime_data<=cur, prime_valid<=1, go EMIT.
//     Not prime and cur==hi -> DONE.
//     Not prime otherwise -> cur<=cur+1, stay SCAN.
//     Cost: 1 cycle per non-prime value.
//   EMIT: hold prime_valid/prime_data stable until prime_valid&prime_ready.
//     On handshake: prime_valid<=0, prime_count<=prime_count+1.
//     Then cur==hi -> DONE, else cur<=cur+1 and go SCAN.
//     Each prime costs >=2 cycles.
//   DONE: done=1 for exactly one cycle, busy=0, go IDLE.
//     prime_count holds its value until the next accepted start.
//   Wrap-around: cur never increments past hi; the equality check happens before the increment.
//     Hence hi=2^WIDTH-1 terminates without cur wrapping to 0.
//   start while busy or in DONE: ignored (no re-latch, no restart).
//   lo==hi: single value tested; emits at most one prime.
//   prime_ready while prime_valid=0: ignored.
//   Reset mid-scan: immediate return to reset values.
//     Any pending prime_valid drops asynchronously with no handshake.
//   Primality: 0 and 1 are not prime. For WIDTH=4 the primes are {2,3,5,7,11,13}.
//   prime_count never overflows: at most 2^(WIDTH-1) primes.
// STRUCTURE
//   Package prime_pkg: state enum (IDLE=2'd0, SCAN=2'd1, EMIT=2'd2, DONE=2'd3);
//     function prime_mask(WIDTH) returning a 2^WIDTH-bit constant.
//   Sub-module prime_flag #(WIDTH): combinational, is_prime = prime_mask[value].
//   The controller holds FSM, cur, hi_q, prime_count and output registers.
// TESTING
//   1. lo=0, hi=15, prime_ready=1 -> prime_data seq 2,3,5,7,11,13;
//      done one cycle; prime_count=6; busy low after done.
//   2. lo=9, hi=3, start -> DONE the next cycle, done pulse, prime_count=0, no prime_valid.
//   3. lo=hi=7 -> one emit of 7, prime_count=1; lo=hi=9 -> no emit, prime_count=0.
//   4. lo=0, hi=15, prime_ready held 0 for 5 cycles on the 11 emit ->
//      prime_valid/prime_data=11 stable throughout; no skipped or duplicated primes.
//   5. start pulsed again mid-scan with lo=0, hi=1 ->
//      ignored; original scan completes with count 6.
//   6. rst_n low during EMIT of 5 -> all outputs 0 immediately;
//      a new start after release runs a clean scan.

Source files
------------

// File: rtl/prime_pkg.sv
// Shared types and the elaboration-time primality table for the prime scan sequencer.
package prime_pkg;

  localparam int MAX_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Bit n of the result is set when n is prime. Only the low 2**width bits are meaningful.
  function automatic logic [(1<<MAX_WIDTH)-1:0] prime_mask(input int width);
    logic [(1<<MAX_WIDTH)-1:0] m;
    logic                      p;
    m = '0;
    for (int n = 2; n < (1 << width); n++) begin
      p = 1'b1;
      for (int d = 2; d * d <= n; d++) begin
        if (n % d == 0) p = 1'b0;
      end
      m[n] = p;
    end
    return m;
  endfunction

endpackage

// File: rtl/prime_flag.sv
// Combinational primality lookup; the table is a constant built at elaboration.
module prime_flag
  import prime_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] value,
  output logic             is_prime
);

  localparam logic [(1<<MAX_WIDTH)-1:0] FULL_MASK = prime_mask(WIDTH);
  localparam logic [(1<<WIDTH)-1:0]     MASK      = FULL_MASK[(1<<WIDTH)-1:0];

  assign is_prime = MASK[value];

endmodule

// File: rtl/prime_scan_ctrl.sv
// Sweeps [lo..hi] through the primality lookup and streams each prime over valid/ready.
// state | meaning
// IDLE  | waiting for start; last prime_count held
// SCAN  | testing cur, one cycle per value
// EMIT  | prime_data presented, waiting for handshake
// DONE  | one-cycle done pulse, then back to IDLE
module prime_scan_ctrl
  import prime_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic             busy,
  output logic             done,
  output logic             prime_valid,
  input  logic             prime_ready,
  output logic [WIDTH-1:0] prime_data,
  output logic [WIDTH:0]   prime_count
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH:0]   count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cur_is_prime;

  prime_flag #(.WIDTH(WIDTH)) u_flag (
    .value    (cur_q),
    .is_prime (cur_is_prime)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      hi_q    <= '0;
      count_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      hi_q    <= hi_d;
      count_q <= count_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    hi_d    = hi_q;
    count_d = count_q;
    data_d  = data_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          hi_d    = hi;
          cur_d   = lo;
          count_d = '0;
          state_d = (lo > hi) ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (cur_is_prime) begin
          data_d  = cur_q;
          valid_d = 1'b1;
          state_d = EMIT;
        end else if (cur_q == hi_q) begin
          state_d = DONE;
        end else begin
          cur_d = cur_q + WIDTH'(1);
        end
      end
      EMIT: begin
        // Compare against hi before incrementing so hi = all-ones never wraps cur.
        if (valid_q && prime_ready) begin
          valid_d = 1'b0;
          count_d = count_q + (WIDTH+1)'(1);
          if (cur_q == hi_q) begin
            state_d = DONE;
          end else begin
            cur_d   = cur_q + WIDTH'(1);
            state_d = SCAN;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == SCAN) || (state_d == EMIT);
    done_d = (state_d == DONE);
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign prime_valid = valid_q;
  assign prime_data  = data_q;
  assign prime_count = count_q;

endmodule

// File: tb/tb_prime_scan_ctrl.sv
// Directed bench for prime_scan_ctrl (WIDTH=4): sequences, cycle costs, stalls, restarts, reset.
module tb_prime_scan_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] lo, hi;
  logic         busy, done, prime_valid, prime_ready;
  logic [W-1:0] prime_data;
  logic [W:0]   prime_count;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] got_sig;
  int          got_n, busy_cyc;
  bit          timed_out;

  always #5 clk = ~clk;

  prime_scan_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .lo          (lo),
    .hi          (hi),
    .busy        (busy),
    .done        (done),
    .prime_valid (prime_valid),
    .prime_ready (prime_ready),
    .prime_data  (prime_data),
    .prime_count (prime_count)
  );

  task automatic do_start(input logic [W-1:0] l, input logic [W-1:0] h);
    @(posedge clk); #1;
    start = 1'b1; lo = l; hi = h;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs until done is seen at a negedge; accepted primes are packed as nibbles into got_sig.
  task automatic collect(input int stall_val, input int stall_n, input int inject_at);
    int stalls = 0;
    bit stalled_prev = 1'b0;
    timed_out = 1'b1;
    got_sig = '0; got_n = 0; busy_cyc = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (cyc == inject_at) begin
        start = 1'b1; lo = 4'd0; hi = 4'd1;
      end else begin
        start = 1'b0;
      end
      if (stalled_prev) begin
        checks++;
        if (prime_valid !== 1'b1 || prime_data !== W'(stall_val)) begin
          errors++;
          $display("FAIL stall_hold: valid=%0b data=%0d, required valid=1 data=%0d",
                   prime_valid, prime_data, stall_val);
        end
      end
      stalled_prev = 1'b0;
      if (busy) busy_cyc++;
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      if (prime_valid) begin
        if (int'(prime_data) == stall_val && stalls < stall_n) begin
          prime_ready = 1'b0;
          stalls++;
          stalled_prev = 1'b1;
        end else begin
          prime_ready = 1'b1;
          got_sig = {got_sig[59:0], prime_data};
          got_n++;
        end
      end else begin
        prime_ready = 1'b1;
      end
    end
    start = 1'b0;
    prime_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; lo = '0; hi = '0; prime_ready = 1'b1;
    #12;
    checks++;
    if ({busy, done, prime_valid, prime_data, prime_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%0b done=%0b valid=%0b data=%0d count=%0d, required all 0",
               busy, done, prime_valid, prime_data, prime_count);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: busy=%0b done=%0b, required 0 0", busy, done);
    end
  endtask

  task automatic test_full_scan(input string name, input int stall_val, input int stall_n,
                                input int inject_at, input int exp_busy);
    do_start(4'd0, 4'd15);
    collect(stall_val, stall_n, inject_at);
    checks++;
    if (timed_out) begin errors++; $display("FAIL %s_timeout: done not seen, required done", name); end
    checks++;
    if (got_n !== 6 || got_sig !== 64'h2357BD) begin
      errors++;
      $display("FAIL %s_seq: n=%0d sig=%h, required n=6 sig=2357bd", name, got_n, got_sig);
    end
    checks++;
    if (busy_cyc !== exp_busy) begin
      errors++;
      $display("FAIL %s_cycles: busy=%0d, required %0d", name, busy_cyc, exp_busy);
    end
    checks++;
    if (busy !== 1'b0 || prime_count !== 5'd6 || prime_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_at_done: busy=%0b count=%0d valid=%0b, required 0 6 0",
               name, busy, prime_count, prime_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || prime_count !== 5'd6) begin
      errors++;
      $display("FAIL %s_after_done: done=%0b busy=%0b count=%0d, required 0 0 6",
               name, done, busy, prime_count);
    end
  endtask

  task automatic test_short(input string name, input logic [W-1:0] l, input logic [W-1:0] h,
                            input int exp_n, input logic [63:0] exp_sig, input int exp_busy);
    do_start(l, h);
    collect(-1, 0, -1);
    checks++;
    if (timed_out) begin errors++; $display("FAIL %s_timeout: done not seen, required done", name); end
    checks++;
    if (got_n !== exp_n || got_sig !== exp_sig) begin
      errors++;
      $display("FAIL %s_seq: n=%0d sig=%h, required n=%0d sig=%h", name, got_n, got_sig, exp_n, exp_sig);
    end
    checks++;
    if (busy_cyc !== exp_busy || prime_count !== (W+1)'(exp_n)) begin
      errors++;
      $display("FAIL %s_cost_count: busy=%0d count=%0d, required %0d %0d",
               name, busy_cyc, prime_count, exp_busy, exp_n);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || prime_count !== (W+1)'(exp_n)) begin
      errors++;
      $display("FAIL %s_after_done: done=%0b count=%0d, required 0 %0d", name, done, prime_count, exp_n);
    end
  endtask

  task automatic test_reset_mid_emit();
    bit found = 1'b0;
    do_start(4'd0, 4'd15);
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      if (prime_valid && prime_data == 4'd5) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rst_emit_reach: prime 5 not seen, required 5"); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, prime_valid, prime_data, prime_count} !== '0) begin
      errors++;
      $display("FAIL rst_emit_outputs: busy=%0b done=%0b valid=%0b data=%0d count=%0d, required all 0",
               busy, done, prime_valid, prime_data, prime_count);
    end
    @(negedge clk); rst_n = 1'b1;
    test_full_scan("rst_rescan", -1, 0, -1, 22);
  endtask

  initial begin
    test_reset();
    test_full_scan("full", -1, 0, -1, 22);
    test_short("lo_gt_hi", 4'd9, 4'd3, 0, 64'h0, 0);
    test_short("single7", 4'd7, 4'd7, 1, 64'h7, 2);
    test_short("single9", 4'd9, 4'd9, 0, 64'h0, 1);
    test_short("top_range", 4'd13, 4'd15, 1, 64'hD, 4);
    test_full_scan("stall11", 11, 5, -1, 27);
    test_full_scan("restart_ignored", -1, 0, 3, 22);
    test_reset_mid_emit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
